// File: rtl/spider_hit_detector.sv
// Per-frame spider/bullet collision scan with kill/consume pulses and saturating score.
// Latency: frame_tick to pulses is 4*NUM_BULLETS+3 cycles. Ticks while busy are dropped and flagged sticky.
// Optional SPIDER_HIT_LAST_POS_EN adds last_hit_x/last_hit_y for the explosion sprite.
module spider_hit_detector #(
  parameter int unsigned NUM_BULLETS    = 4,
  parameter int unsigned SPIDER_W       = 32,
  parameter int unsigned BULLET_W       = 4,
  parameter int unsigned BULLET_H       = 8,
  parameter int unsigned SCORE_PER_KILL = 10
) (
  input  logic                      clk25,
  input  logic                      reset_n,
  input  logic                      frame_tick,
  input  logic [39:0]               spider_x_bus,
  input  logic [39:0]               spider_y_bus,
  input  logic [3:0]                spider_alive,
  input  logic [10*NUM_BULLETS-1:0] bullet_x_bus,
  input  logic [10*NUM_BULLETS-1:0] bullet_y_bus,
  input  logic [NUM_BULLETS-1:0]    bullet_active,
  output logic [3:0]                spider_kill,
  output logic [NUM_BULLETS-1:0]    bullet_hit,
  output logic [15:0]               score,
  output logic                      busy,
  output logic                      scan_done,
  output logic                      tick_overrun
`ifdef SPIDER_HIT_LAST_POS_EN
  ,
  output logic [9:0]                last_hit_x,
  output logic [9:0]                last_hit_y
`endif
);

  localparam int BI = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;

  typedef enum logic [1:0] {IDLE, SNAP, SCAN, COMMIT} state_t;

  state_t                    state_q;
  logic [39:0]               sx_q, sy_q;
  logic [3:0]                alive_q;
  logic [10*NUM_BULLETS-1:0] bx_q, by_q;
  logic [NUM_BULLETS-1:0]    act_q;
  logic [3:0]                killed_q;
  logic [NUM_BULLETS-1:0]    used_q;
  logic [1:0]                s_q;
  logic [BI-1:0]             b_q;
  logic [3:0]                kill_q;
  logic [NUM_BULLETS-1:0]    hit_q;
  logic [15:0]               score_q;
  logic                      busy_q, done_q, overrun_q;

  logic [10:0] sx, sy, bx, by;
  logic        overlap, pair_hit_d;
  logic [16:0] score_sum;
  logic [15:0] score_d;

  // Operands are widened to 11 bits so boxes near the right/bottom edge never wrap.
  always_comb begin
    sx         = {1'b0, sx_q[int'(s_q)*10 +: 10]};
    sy         = {1'b0, sy_q[int'(s_q)*10 +: 10]};
    bx         = {1'b0, bx_q[int'(b_q)*10 +: 10]};
    by         = {1'b0, by_q[int'(b_q)*10 +: 10]};
    overlap    = (bx < sx + 11'(SPIDER_W)) && (sx < bx + 11'(BULLET_W)) &&
                 (by < sy + 11'(SPIDER_W)) && (sy < by + 11'(BULLET_H));
    pair_hit_d = alive_q[s_q] & act_q[b_q] & ~killed_q[s_q] & ~used_q[b_q] & overlap;
    score_sum  = {1'b0, score_q} + 17'($countones(killed_q) * SCORE_PER_KILL);
    score_d    = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end

`ifdef SPIDER_HIT_LAST_POS_EN
  logic [9:0] last_x_q, last_y_q, last_x_d, last_y_d;

  always_comb begin
    last_x_d = last_x_q;
    last_y_d = last_y_q;
    for (int i = 3; i >= 0; i--) begin
      if (killed_q[i]) begin
        last_x_d = sx_q[10*i +: 10];
        last_y_d = sy_q[10*i +: 10];
      end
    end
  end

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      last_x_q <= '0;
      last_y_q <= '0;
    end else if (state_q == COMMIT) begin
      last_x_q <= last_x_d;
      last_y_q <= last_y_d;
    end
  end

  assign last_hit_x = last_x_q;
  assign last_hit_y = last_y_q;
`endif

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      sx_q      <= '0;
      sy_q      <= '0;
      alive_q   <= '0;
      bx_q      <= '0;
      by_q      <= '0;
      act_q     <= '0;
      killed_q  <= '0;
      used_q    <= '0;
      s_q       <= '0;
      b_q       <= '0;
      kill_q    <= '0;
      hit_q     <= '0;
      score_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      kill_q <= '0;
      hit_q  <= '0;
      done_q <= 1'b0;
      if (frame_tick && state_q != IDLE) overrun_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (frame_tick) begin
            state_q <= SNAP;
            busy_q  <= 1'b1;
          end
        end
        SNAP: begin
          sx_q     <= spider_x_bus;
          sy_q     <= spider_y_bus;
          alive_q  <= spider_alive;
          bx_q     <= bullet_x_bus;
          by_q     <= bullet_y_bus;
          act_q    <= bullet_active;
          killed_q <= '0;
          used_q   <= '0;
          s_q      <= '0;
          b_q      <= '0;
          state_q  <= SCAN;
        end
        SCAN: begin
          if (pair_hit_d) begin
            killed_q[s_q] <= 1'b1;
            used_q[b_q]   <= 1'b1;
          end
          if (b_q == BI'(NUM_BULLETS - 1)) begin
            b_q <= '0;
            if (s_q == 2'd3) state_q <= COMMIT;
            else             s_q     <= s_q + 2'd1;
          end else begin
            b_q <= b_q + BI'(1);
          end
        end
        COMMIT: begin
          kill_q  <= killed_q;
          hit_q   <= used_q;
          done_q  <= 1'b1;
          score_q <= score_d;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign spider_kill  = kill_q;
  assign bullet_hit   = hit_q;
  assign score        = score_q;
  assign busy         = busy_q;
  assign scan_done    = done_q;
  assign tick_overrun = overrun_q;

endmodule

// File: tb/tb_spider_hit_detector.sv
// Scoreboard bench for spider_hit_detector: expected pulses/score queued at each tick, checked at scan_done.
module tb_spider_hit_detector;
  localparam int NB = 4;

  logic            clk25 = 1'b0;
  logic            reset_n = 1'b0;
  logic            frame_tick = 1'b0;
  logic [39:0]     sxb = '0, syb = '0;
  logic [3:0]      alive = '0;
  logic [10*NB-1:0] bxb = '0, byb = '0;
  logic [NB-1:0]   act = '0;
  logic [3:0]      spider_kill;
  logic [NB-1:0]   bullet_hit;
  logic [15:0]     score;
  logic            busy, scan_done, tick_overrun;
`ifdef SPIDER_HIT_LAST_POS_EN
  logic [9:0]      last_hit_x, last_hit_y;
`endif

  spider_hit_detector #(.NUM_BULLETS(NB)) dut (
    .clk25(clk25), .reset_n(reset_n), .frame_tick(frame_tick),
    .spider_x_bus(sxb), .spider_y_bus(syb), .spider_alive(alive),
    .bullet_x_bus(bxb), .bullet_y_bus(byb), .bullet_active(act),
    .spider_kill(spider_kill), .bullet_hit(bullet_hit), .score(score),
    .busy(busy), .scan_done(scan_done), .tick_overrun(tick_overrun)
`ifdef SPIDER_HIT_LAST_POS_EN
    , .last_hit_x(last_hit_x), .last_hit_y(last_hit_y)
`endif
  );

  always #20 clk25 = ~clk25;

  int cyc = 0;
  always @(posedge clk25) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]    k;
    logic [NB-1:0] h;
    logic [15:0]   sc;
    int            due;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int failures = 0;
  int exp_score = 0;
  int sxa[4], sya[4], bxa[NB], bya[NB];
  logic [3:0]    al;
  logic [NB-1:0] ac;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference pairing: spiders outer, bullets inner, first free overlapping pair wins.
  task automatic model(output logic [3:0] k, output logic [NB-1:0] h);
    k = '0;
    h = '0;
    for (int s = 0; s < 4; s++)
      for (int b = 0; b < NB; b++)
        if (al[s] && ac[b] && !k[s] && !h[b] &&
            bxa[b] < sxa[s] + 32 && sxa[s] < bxa[b] + 4 &&
            bya[b] < sya[s] + 32 && sya[s] < bya[b] + 8) begin
          k[s] = 1'b1;
          h[b] = 1'b1;
        end
  endtask

  task automatic clear_cfg();
    al = '0;
    ac = '0;
    for (int i = 0; i < 4; i++) begin sxa[i] = 0; sya[i] = 0; end
    for (int j = 0; j < NB; j++) begin bxa[j] = 0; bya[j] = 0; end
  endtask

  // Called at a negedge; returns two negedges later after scrambling the live inputs.
  task automatic start_frame();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      sxb[10*i +: 10] = 10'(sxa[i]);
      syb[10*i +: 10] = 10'(sya[i]);
    end
    for (int j = 0; j < NB; j++) begin
      bxb[10*j +: 10] = 10'(bxa[j]);
      byb[10*j +: 10] = 10'(bya[j]);
    end
    alive = al;
    act = ac;
    model(e.k, e.h);
    exp_score = exp_score + 10 * $countones(e.k);
    if (exp_score > 65535) exp_score = 65535;
    e.sc = 16'(exp_score);
    e.due = cyc + 19;
    q.push_back(e);
    frame_tick = 1'b1;
    @(negedge clk25);
    frame_tick = 1'b0;
    @(negedge clk25);
    sxb = {$urandom, $urandom};
    syb = {$urandom, $urandom};
    bxb = {$urandom, $urandom};
    byb = {$urandom, $urandom};
    alive = 4'($urandom);
    act = NB'($urandom);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk25);
    check("done_timeout", q.size(), 0);
    q.delete();
    @(negedge clk25);
  endtask

  logic prev_done = 1'b0;
  always @(negedge clk25) begin
    if (prev_done) check("pulse_clear", {spider_kill, bullet_hit, scan_done}, 0);
    prev_done <= scan_done;
    if (scan_done) begin
      if (q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("kill", spider_kill, e.k);
        check("bullet_hit", bullet_hit, e.h);
        check("score", score, e.sc);
        check("latency", cyc, e.due);
      end
    end
  end

  initial begin
    clear_cfg();
    repeat (3) @(negedge clk25);
    reset_n = 1'b1;

    // Idle with no tick: everything stays low.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk25);
      check("idle_outputs", {spider_kill, bullet_hit, score, busy, scan_done, tick_overrun}, 0);
    end

    // Single overlap.
    clear_cfg();
    al = 4'b0001; sxa[0] = 128; sya[0] = 100;
    ac = 4'b0001; bxa[0] = 140; bya[0] = 110;
    start_frame();
    check("busy_in_scan", busy, 1);
    wait_done();
    check("first_score", score, 16'd10);
    check("busy_idle", busy, 0);

    // Touching edge is a miss, one pixel in is a hit.
    clear_cfg();
    al = 4'b0010; sxa[1] = 288; sya[1] = 50;
    ac = 4'b0001; bxa[0] = 320; bya[0] = 50;
    start_frame(); wait_done();
    bxa[0] = 319;
    start_frame(); wait_done();

    // Shared bullet: lowest spider takes it, next bullet goes to spider1.
    clear_cfg();
    al = 4'b0011; sxa[0] = 100; sya[0] = 100; sxa[1] = 110; sya[1] = 100;
    ac = 4'b0011; bxa[0] = 115; bya[0] = 110; bxa[1] = 138; bya[1] = 110;
    start_frame(); wait_done();

    // Tick during the pulse cycle is accepted.
    start_frame();
    for (int i = 0; i < 60 && !scan_done; i++) @(negedge clk25);
    start_frame(); wait_done();

    // Random configurations, clustered so hits are common, plus far-edge positions.
    for (int n = 0; n < 24; n++) begin
      int base;
      base = (n % 3 == 0) ? 960 : 100;
      al = 4'($urandom);
      ac = NB'($urandom);
      for (int i = 0; i < 4; i++) begin
        sxa[i] = base + $urandom_range(0, 60);
        sya[i] = base + $urandom_range(0, 60);
      end
      for (int j = 0; j < NB; j++) begin
        bxa[j] = base + $urandom_range(0, 63);
        bya[j] = base + $urandom_range(0, 63);
      end
      start_frame(); wait_done();
    end

    // Drive score toward saturation.
    clear_cfg();
    for (int i = 0; i < 4; i++) begin
      sxa[i] = 100 * i; sya[i] = 0; bxa[i] = 100 * i + 10; bya[i] = 10;
    end
    al = 4'hF; ac = 4'hF;
    while (exp_score <= 65530 - 40) begin start_frame(); wait_done(); end
    al = 4'b0001; ac = 4'b0001;
    while (exp_score < 65530) begin start_frame(); wait_done(); end
    check("preset_score", score, 16'd65530);
    start_frame(); wait_done();
    check("saturate", score, 16'hFFFF);
    start_frame(); wait_done();
    check("saturate_hold", score, 16'hFFFF);

    // Tick in the middle of a scan: dropped, sticky flag, still one scan_done.
    check("overrun_clear", tick_overrun, 0);
    start_frame();
    repeat (4) @(negedge clk25);
    frame_tick = 1'b1;
    @(negedge clk25);
    frame_tick = 1'b0;
    wait_done();
    repeat (30) @(negedge clk25);
    check("overrun_set", tick_overrun, 1);

    // Reset mid-scan: immediate clear, no pulses afterwards.
    clear_cfg();
    al = 4'b0001; sxa[0] = 128; sya[0] = 100;
    ac = 4'b0001; bxa[0] = 140; bya[0] = 110;
    frame_tick = 1'b1;
    @(negedge clk25);
    frame_tick = 1'b0;
    repeat (6) @(negedge clk25);
    check("busy_before_reset", busy, 1);
    reset_n = 1'b0;
    #1;
    check("reset_outputs", {spider_kill, bullet_hit, score, busy, scan_done, tick_overrun}, 0);
    @(negedge clk25);
    reset_n = 1'b1;
    exp_score = 0;
    repeat (40) @(negedge clk25);
    check("post_reset_score", score, 0);
    check("post_reset_busy", busy, 0);

    // Recovery after reset.
    start_frame(); wait_done();
    check("recover_score", score, 16'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
